// File: rtl/pipe_pkg.sv
// Shared definitions for the buffered pipeline stage: FSM encoding,
// default widths and the bubble control word.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int          PIPE_DATA_W   = 16;
  localparam int          PIPE_N_FIELDS = 4;
  localparam int          PIPE_CTRL_W   = 16;
  localparam logic [15:0] PIPE_NOP_CTRL = 16'h0000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage: valid bit plus control/data payload.
// Clear wins over load and returns the slot to a bubble.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = PIPE_CTRL_W,
  parameter int                PAY_W    = PIPE_DATA_W * PIPE_N_FIELDS,
  parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(PIPE_NOP_CTRL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [PAY_W-1:0]  ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [PAY_W-1:0]  data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [PAY_W-1:0]  data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      ctrl_d  = NOP_CTRL;
      data_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = ld_ctrl;
      data_d  = ld_data;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= NOP_CTRL;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_buff.sv
// Two-entry skid-buffered pipeline register with halt, flush and a
// saturating stall counter. M presents downstream, S absorbs one stalled entry.
module pipe_stage_buff
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = PIPE_DATA_W,
  parameter int                N_FIELDS = PIPE_N_FIELDS,
  parameter int                CTRL_W   = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(PIPE_NOP_CTRL)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       halt,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [N_FIELDS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [N_FIELDS*DATA_W-1:0] out_data,
  output logic [1:0]                 occupancy,
  output logic [15:0]                stall_cnt
);

  localparam int PAY_W = N_FIELDS * DATA_W;

  pipe_state_e       state_q, state_d;
  logic [15:0]       stall_q, stall_d;
  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ld_ctrl;
  logic [PAY_W-1:0]  m_data, s_data, m_ld_data;
  logic              m_load, m_clr, m_from_s, s_load, s_clr;
  logic              push, pop;

  // Ready depends only on held state and stage controls, never on out_ready.
  assign in_ready  = rst && !s_valid && !halt && !flush;
  assign out_valid = m_valid && !halt;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_ctrl  = m_valid ? m_ctrl : NOP_CTRL;
  assign out_data  = m_data;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    m_clr    = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
      m_clr   = 1'b1;
      s_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            m_load  = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            m_load = 1'b1;
          end else if (push) begin
            state_d = ST_FULL;
            s_load  = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
            m_clr   = 1'b1;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d  = ST_ONE;
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_clr    = 1'b1;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          m_clr   = 1'b1;
          s_clr   = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    m_ld_ctrl = in_ctrl;
    m_ld_data = in_data;
    if (m_from_s) begin
      m_ld_ctrl = s_ctrl;
      m_ld_data = s_data;
    end else begin
      m_ld_ctrl = in_ctrl;
      m_ld_data = in_data;
    end
  end

  // Halt counts as a stall even when M is empty; flush leaves the count alone.
  always_comb begin
    stall_d = stall_q;
    if ((m_valid && !out_ready) || halt) begin
      stall_d = sat_inc16(stall_q);
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W), .NOP_CTRL(NOP_CTRL)) u_slot_m (
    .clk     (clk),
    .rst     (rst),
    .load    (m_load),
    .clr     (m_clr),
    .ld_ctrl (m_ld_ctrl),
    .ld_data (m_ld_data),
    .valid   (m_valid),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W), .NOP_CTRL(NOP_CTRL)) u_slot_s (
    .clk     (clk),
    .rst     (rst),
    .load    (s_load),
    .clr     (s_clr),
    .ld_ctrl (in_ctrl),
    .ld_data (in_data),
    .valid   (s_valid),
    .ctrl    (s_ctrl),
    .data    (s_data)
  );

endmodule

// File: doc/pipe_stage_buff.md
PIPE_STAGE_BUFF -- requirements
Module: pipe_stage_buff

Interface
REQ-001 Parameter DATA_W, default 16: width of one data field.
REQ-002 Parameter N_FIELDS, default 4: number of data fields per entry (reg_1, reg_2, sign-ext, instruction).
REQ-003 Parameter CTRL_W, default 16: width of the packed control word (write-back, memory and execute fields).
REQ-004 Parameter NOP_CTRL, default all zeros: control word loaded on bubble or flush.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 flush  in  1  active-high synchronous squash of all held entries.
REQ-008 halt  in  1  active-high freeze of the stage.
REQ-009 in_valid  in  1  upstream entry present.
REQ-010 in_ready  out  1  stage accepts an entry this cycle.
REQ-011 in_ctrl  in  CTRL_W  upstream control word.
REQ-012 in_data  in  N_FIELDS*DATA_W  upstream fields; field 0 occupies the LSBs.
REQ-013 out_valid  out  1  entry presented downstream.
REQ-014 out_ready  in  1  downstream accepts.
REQ-015 out_ctrl  out  CTRL_W  control word of the head entry.
REQ-016 out_data  out  N_FIELDS*DATA_W  data of the head entry.
REQ-017 occupancy  out  2  number of held entries (0..2).
REQ-018 stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-019 The stage SHALL hold up to two entries: main slot M drives out_*, and skid slot S absorbs one entry when downstream stalls.
REQ-020 Push = in_valid && in_ready; pop = out_valid && out_ready; entries SHALL leave in arrival order.
REQ-021 in_ready SHALL be !S_valid && !halt && !flush, derived combinationally from registered state only, with no path from out_ready.
REQ-022 out_valid SHALL be M_valid && !halt.
REQ-023 The FSM SHALL have states EMPTY, ONE and FULL, with occupancy = 0/1/2.
REQ-024 EMPTY: push -> ONE (entry loaded into M); latency from push to out_valid is 1 cycle.
REQ-025 ONE: push && pop -> ONE (M replaced); push && !pop -> FULL (entry into S); pop && !push -> EMPTY.
REQ-026 FULL: pop -> ONE (S moves to M, S cleared); no push is possible in FULL.
REQ-027 halt=1 SHALL freeze all slots and state, regardless of in_valid and out_ready.
REQ-028 flush=1 SHALL, at the next edge, go to EMPTY: M_valid and S_valid cleared, both ctrl slots set to NOP_CTRL, both data slots zeroed.
REQ-029 flush SHALL take priority over halt, push and pop in the same cycle.
REQ-030 When M is invalid, out_ctrl SHALL equal NOP_CTRL, so downstream always sees a bubble.
REQ-031 stall_cnt SHALL increment on any cycle with (M_valid && !out_ready) || halt, saturating at 16'hFFFF; flush SHALL NOT clear it.

Reset
REQ-032 On rst=0, asynchronously: state=EMPTY, M_valid=S_valid=0, ctrl slots=NOP_CTRL, data slots=0, stall_cnt=0.
REQ-033 During reset, outputs SHALL be: out_valid=0, in_ready=0, occupancy=0, out_ctrl=NOP_CTRL, out_data=0.
REQ-034 After rst deasserts, in_ready SHALL be 1 on the first cycle (unless halt or flush is asserted); reset mid-transfer SHALL discard all entries.

Structure
REQ-035 A shared package pipe_pkg SHALL hold the FSM state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2), the default widths and the NOP_CTRL default.
REQ-036 A sub-module pipe_slot (a valid bit plus ctrl/data register with load and clear) SHALL be instantiated twice, for M and S.

Verification
REQ-037 Reset, then push ctrl=16'h00A5, data={16'h4,16'h3,16'h2,16'h1} with out_ready=1 -> out_valid=1 next cycle with identical data; occupancy 0->1->0.
REQ-038 out_ready=0, push A, B -> occupancy=2, in_ready=0; then out_ready=1 -> A then B on consecutive cycles, no loss or duplication.
REQ-039 FULL with halt=1 for 5 cycles -> out_valid=0, state unchanged, stall_cnt advances by 5.
REQ-040 FULL with flush=1, halt=1 and in_valid=1 in the same cycle -> next cycle occupancy=0, out_ctrl=NOP_CTRL, out_data=0.
REQ-041 Assert rst=0 asynchronously mid-stream while occupancy=2 -> immediate out_valid=0 and stall_cnt=0; first push after release appears 1 cycle later.
REQ-042 Hold out_ready=0 with M_valid=1 for 70000 cycles -> stall_cnt saturates at 16'hFFFF and does not wrap.
